// File: rtl/quadra_coef_table_pkg.sv
// Shared widths, typedefs and enums for the quadratic-interpolation coefficient store.
package quadra_pkg;

    localparam int X1_W_D  = 7;
    localparam int X2_W_D  = 16;
    localparam int A_W_D   = 24;
    localparam int B_W_D   = 19;
    localparam int C_W_D   = 13;
    localparam int BANKS_D = 2;

    typedef logic [X1_W_D-1:0] x1_t;
    typedef logic [X2_W_D-1:0] x2_t;
    typedef logic [A_W_D-1:0]  a_t;
    typedef logic [B_W_D-1:0]  b_t;
    typedef logic [C_W_D-1:0]  c_t;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_C    = 2'd2,
        SEL_NONE = 2'd3
    } coef_sel_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tbl_state_e;

    // A single bank still needs a 1-bit select so the port is never zero width.
    function automatic int bank_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/quadra_coef_ram.sv
// One coefficient bank: 1R1W, registered read, per-field write enables, read-before-write.
module quadra_coef_ram
    import quadra_pkg::*;
#(
    parameter int AW  = X1_W_D,
    parameter int A_W = A_W_D,
    parameter int B_W = B_W_D,
    parameter int C_W = C_W_D
) (
    input  logic           clk,
    input  logic           i_re,
    input  logic [AW-1:0]  i_raddr,
    output logic [A_W-1:0] o_a,
    output logic [B_W-1:0] o_b,
    output logic [C_W-1:0] o_c,
    input  logic [AW-1:0]  i_waddr,
    input  logic           i_we_a,
    input  logic           i_we_b,
    input  logic           i_we_c,
    input  logic [A_W-1:0] i_wa,
    input  logic [B_W-1:0] i_wb,
    input  logic [C_W-1:0] i_wc
);

    logic [A_W-1:0] r_mem_a [2**AW];
    logic [B_W-1:0] r_mem_b [2**AW];
    logic [C_W-1:0] r_mem_c [2**AW];
    logic [A_W-1:0] r_rd_a;
    logic [B_W-1:0] r_rd_b;
    logic [C_W-1:0] r_rd_c;

    // Read and write share one edge; non-blocking semantics give the old word on a collision.
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem_a[i_waddr] <= i_wa;
        if (i_we_b) r_mem_b[i_waddr] <= i_wb;
        if (i_we_c) r_mem_c[i_waddr] <= i_wc;
        if (i_re) begin
            r_rd_a <= r_mem_a[i_raddr];
            r_rd_b <= r_mem_b[i_raddr];
            r_rd_c <= r_mem_c[i_raddr];
        end
    end

    assign o_a = r_rd_a;
    assign o_b = r_rd_b;
    assign o_c = r_rd_c;

endmodule

// File: rtl/quadra_coef_table.sv
// Banked, pipelined coefficient table: post-reset clear sequence, runtime writes, valid/ready lookup.
module quadra_coef_table
    import quadra_pkg::*;
#(
    parameter  int X1_W  = X1_W_D,
    parameter  int X2_W  = X2_W_D,
    parameter  int A_W   = A_W_D,
    parameter  int B_W   = B_W_D,
    parameter  int C_W   = C_W_D,
    parameter  int BANKS = BANKS_D,
    localparam int BK_W  = bank_w(BANKS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BK_W-1:0] in_bank,
    input  logic [X1_W-1:0] in_x1,
    input  logic [X2_W-1:0] in_x2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [A_W-1:0]  out_a,
    output logic [B_W-1:0]  out_b,
    output logic [C_W-1:0]  out_c,
    output logic [X2_W-1:0] out_x2,
    input  logic            wr_en,
    input  logic [BK_W-1:0] wr_bank,
    input  logic [X1_W-1:0] wr_addr,
    input  logic [1:0]      wr_sel,
    input  logic [A_W-1:0]  wr_data,
    output logic            init_done,
    output tbl_state_e      dbg_state
);

    tbl_state_e      r_state;
    tbl_state_e      w_state_nxt;
    logic [X1_W-1:0] r_clr_addr;
    logic            w_run;
    logic            w_en;
    coef_sel_e       w_wsel;
    logic [X1_W-1:0] w_waddr;
    logic [A_W-1:0]  w_wa;
    logic [B_W-1:0]  w_wb;
    logic [C_W-1:0]  w_wc;

    logic            r_s1_valid;
    logic [BK_W-1:0] r_s1_bank;
    logic [X2_W-1:0] r_s1_x2;

    logic [A_W-1:0]  w_rd_a [BANKS];
    logic [B_W-1:0]  w_rd_b [BANKS];
    logic [C_W-1:0]  w_rd_c [BANKS];
    logic [A_W-1:0]  w_mux_a;
    logic [B_W-1:0]  w_mux_b;
    logic [C_W-1:0]  w_mux_c;

    logic            r_out_valid;
    logic [A_W-1:0]  r_out_a;
    logic [B_W-1:0]  r_out_b;
    logic [C_W-1:0]  r_out_c;
    logic [X2_W-1:0] r_out_x2;

    // Handshake: a request moves when in_valid && in_ready at a rising edge; a result
    // leaves when out_valid && out_ready. The whole pipe advances on one enable, so a
    // stalled output freezes S1, the RAM read registers and S2 together.
    assign w_run     = (r_state == RUN);
    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_run && w_en;
    assign init_done = w_run;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_clr_addr == '1) w_state_nxt = RUN;
    end

    // While clearing, every bank is written with zeros at the clear address.
    assign w_wsel  = coef_sel_e'(wr_sel);
    assign w_waddr = w_run ? wr_addr : r_clr_addr;
    assign w_wa    = w_run ? wr_data : '0;
    assign w_wb    = w_run ? wr_data[B_W-1:0] : '0;
    assign w_wc    = w_run ? wr_data[C_W-1:0] : '0;

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic w_hit;
        assign w_hit = w_run && wr_en && (wr_bank == BK_W'(g));

        quadra_coef_ram #(
            .AW  (X1_W),
            .A_W (A_W),
            .B_W (B_W),
            .C_W (C_W)
        ) u_ram (
            .clk     (clk),
            .i_re    (w_en),
            .i_raddr (in_x1),
            .o_a     (w_rd_a[g]),
            .o_b     (w_rd_b[g]),
            .o_c     (w_rd_c[g]),
            .i_waddr (w_waddr),
            .i_we_a  (!w_run || (w_hit && w_wsel == SEL_A)),
            .i_we_b  (!w_run || (w_hit && w_wsel == SEL_B)),
            .i_we_c  (!w_run || (w_hit && w_wsel == SEL_C)),
            .i_wa    (w_wa),
            .i_wb    (w_wb),
            .i_wc    (w_wc)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_bank  <= '0;
            r_s1_x2    <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid && in_ready;
            r_s1_bank  <= in_bank;
            r_s1_x2    <= in_x2;
        end
    end

    // A bank select with no matching bank falls through to zero.
    always_comb begin
        w_mux_a = '0;
        w_mux_b = '0;
        w_mux_c = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (r_s1_bank == BK_W'(i)) begin
                w_mux_a = w_rd_a[i];
                w_mux_b = w_rd_b[i];
                w_mux_c = w_rd_c[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
            r_out_x2    <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            r_out_a     <= w_mux_a;
            r_out_b     <= w_mux_b;
            r_out_c     <= w_mux_c;
            r_out_x2    <= r_s1_x2;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_c     = r_out_c;
    assign out_x2    = r_out_x2;

endmodule

// File: tb/tb_quadra_coef_table.sv
// Directed bench for quadra_coef_table with an expected-response queue and an output monitor.
module tb_quadra_coef_table;
  import quadra_pkg::*;

  localparam int W = 72;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_bank;
  logic [6:0]  in_x1;
  logic [15:0] in_x2;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_a;
  logic [18:0] out_b;
  logic [12:0] out_c;
  logic [15:0] out_x2;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [6:0]  wr_addr;
  logic [1:0]  wr_sel;
  logic [23:0] wr_data;
  logic        init_done;
  tbl_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [23:0] m_a [2][128];
  logic [18:0] m_b [2][128];
  logic [12:0] m_c [2][128];

  quadra_coef_table dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bank   (in_bank),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_x2    (out_x2),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  function automatic logic [W-1:0] mexp(input int b, input int x, input logic [15:0] x2);
    return {m_a[b][x], m_b[b][x], m_c[b][x], x2};
  endfunction

  // driver tasks: all called just after a rising edge
  task automatic send(input int b, input int x, input logic [15:0] x2, input logic [W-1:0] e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_bank  = 1'(b);
    in_x1    = 7'(x);
    in_x2    = x2;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=ready_low exp=ready_high");
    end
  endtask

  task automatic wr(input int b, input int a, input logic [1:0] sel, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_bank = 1'(b);
    wr_addr = 7'(a);
    wr_sel  = sel;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (sel == 2'd0)      m_a[b][a] = d;
    else if (sel == 2'd1) m_b[b][a] = d[18:0];
    else if (sel == 2'd2) m_c[b][a] = d[12:0];
  endtask

  task automatic do_reset(input bit with_wr);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    wr_en    = 1'b0;
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 128; a++) begin
        m_a[b][a] = '0;
        m_b[b][a] = '0;
        m_c[b][a] = '0;
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_init_done", W'(init_done), W'(0));
    chk("rst_outs", {out_a, out_b, out_c, out_x2}, W'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_bank  = 1'b0;
    in_x1    = 7'd0;
    in_x2    = 16'h00aa;
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_bank = 1'b1;
      wr_addr = 7'd5;
      wr_sel  = 2'd0;
      wr_data = 24'h123456;
    end
    repeat (127) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("init_done_127", W'(init_done), W'(0));
    chk("in_ready_127", W'(in_ready), W'(0));
    @(posedge clk);
    @(negedge clk);
    chk("init_done_128", W'(init_done), W'(1));
    chk("in_ready_128", W'(in_ready), W'(1));
    if (in_ready) exp_q.push_back({56'h0, 16'h00aa});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard monitor
  logic [W-1:0] cur;
  logic [W-1:0] held;
  bit           held_v = 1'b0;

  always @(negedge clk) begin
    cur = {out_a, out_b, out_c, out_x2};
    if (!rst_n) begin
      held_v = 1'b0;
    end else if (out_valid && !out_ready) begin
      if (held_v) chk("stall_hold", cur, held);
      held   = cur;
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got=%h exp=none", cur);
        end else begin
          chk("out_data", cur, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bank   = 1'b0;
    in_x1     = '0;
    in_x2     = '0;
    out_ready = 1'b1;
    wr_en     = 1'b0;
    wr_bank   = 1'b0;
    wr_addr   = '0;
    wr_sel    = '0;
    wr_data   = '0;

    do_reset(1'b0);

    // hand values into bank 0 addr 0; bank 1 addr 0 stays clear
    wr(0, 0, 2'd0, 24'ha57d87);
    wr(0, 0, 2'd1, 24'h016a0c);
    wr(0, 0, 2'd2, 24'h000b39);
    send(0, 0, 16'h1234, {24'ha57d87, 19'h16a0c, 13'h0b39, 16'h1234});
    send(1, 0, 16'h0001, {56'h0, 16'h0001});

    // top address with sign bits set
    wr(0, 127, 2'd0, 24'h800001);
    wr(0, 127, 2'd2, 24'hffffff);
    send(0, 127, 16'hbeef, {24'h800001, 19'h0, 13'h1fff, 16'hbeef});

    // stream the whole bank with a 5-cycle downstream stall in the middle
    fork
      begin
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 128; i++)
      send(0, i, 16'(i * 515 + 3), mexp(0, i, 16'(i * 515 + 3)));

    // same-cycle write and read of bank 1 addr 0x4c
    wr_en   = 1'b1;
    wr_bank = 1'b1;
    wr_addr = 7'h4c;
    wr_sel  = 2'd1;
    wr_data = 24'h07f65f;
    send(1, 7'h4c, 16'h0c0c, {56'h0, 16'h0c0c});
    wr_en = 1'b0;
    m_b[1][7'h4c] = 19'h7f65f;
    send(1, 7'h4c, 16'h0c0d, {24'h0, 19'h7f65f, 13'h0, 16'h0c0d});

    // wr_sel = 3 changes nothing
    wr(0, 7, 2'd3, 24'hffffff);
    send(0, 7, 16'h0707, {56'h0, 16'h0707});

    // reset with two requests in flight
    send(0, 3, 16'h0303, mexp(0, 3, 16'h0303));
    send(0, 4, 16'h0404, mexp(0, 4, 16'h0404));
    chk("inflight_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", W'(out_valid), W'(0));
    chk("rst_drop_outs", {out_a, out_b, out_c, out_x2}, W'(0));
    do_reset(1'b1);

    send(0, 0, 16'h5a5a, {56'h0, 16'h5a5a});
    send(1, 7'h4c, 16'h5a5b, {56'h0, 16'h5a5b});
    send(1, 5, 16'h5a5c, {56'h0, 16'h5a5c});
    send(0, 127, 16'h5a5d, {56'h0, 16'h5a5d});

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
